// File: rtl/hdmi_capture.sv
// hdmi_capture: measures incoming 2-pixel-per-clock video timing, reports lock,
// and on request writes exactly one complete frame into the frame buffer.
module hdmi_capture #(
  parameter int   hRez         = 320,
  parameter int   vRez         = 480,
  parameter logic hsync_active = 1'b0,
  parameter logic vsync_active = 1'b0
) (
  input  logic        clk24,
  input  logic        rst,
  input  logic [47:0] hdmi_data,
  input  logic        hdmi_hsync,
  input  logic        hdmi_vsync,
  input  logic        hdmi_active_video,
  input  logic        cap_start,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        cap_err,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [47:0] wr_data,
  output logic [9:0]  meas_htotal,
  output logic [9:0]  meas_hactive,
  output logic [9:0]  meas_vtotal,
  output logic [9:0]  meas_vactive,
  output logic        locked
);
  localparam logic [18:0] LastAddr = 19'(hRez * vRez - 1);
  localparam logic [9:0]  HRez10   = 10'(hRez);
  localparam logic [9:0]  VRez10   = 10'(vRez);
  localparam logic [10:0] HRez11   = 11'(hRez);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
  state_t state_q, state_d;

  logic [47:0] s_data_q;
  logic        s_hs_q, s_vs_q, s_act_q, d_hs_q, d_vs_q, d_act_q;
  logic        hs_lead, vs_lead, line_end;

  logic [9:0]  hcnt_q, hcnt_d, hact_q, hact_d, vcnt_q, vcnt_d, vact_q, vact_d;
  logic [9:0]  htot_q, htot_d, hactm_q, hactm_d, vtot_q, vtot_d, vactm_q, vactm_d;
  logic [9:0]  p_htot_q, p_htot_d, p_hact_q, p_hact_d;
  logic        locked_q, locked_d;

  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, wr_en_q, wr_en_d;
  logic [18:0] wr_addr_q, wr_addr_d, addr_q, addr_d;
  logic [47:0] wr_data_q, wr_data_d;
  logic [9:0]  line_q, line_d;
  logic [10:0] wcnt_q, wcnt_d;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

  assign hs_lead  = (s_hs_q == hsync_active) && (d_hs_q != hsync_active);
  assign vs_lead  = (s_vs_q == vsync_active) && (d_vs_q != vsync_active);
  assign line_end = d_act_q && !s_act_q;

  always_comb begin
    hcnt_d   = hs_lead ? 10'd1 : sat_inc(hcnt_q);
    htot_d   = hs_lead ? hcnt_q : htot_q;
    hact_d   = line_end ? '0 : (s_act_q ? sat_inc(hact_q) : hact_q);
    hactm_d  = line_end ? hact_q : hactm_q;
    vcnt_d   = hs_lead ? sat_inc(vcnt_q) : vcnt_q;
    vact_d   = line_end ? sat_inc(vact_q) : vact_q;
    vtot_d   = vtot_q;
    vactm_d  = vactm_q;
    p_htot_d = p_htot_q;
    p_hact_d = p_hact_q;
    locked_d = locked_q;
    if (vs_lead) begin
      // An hsync edge or line end coinciding with the vsync edge opens the new frame.
      vtot_d   = vcnt_q;
      vactm_d  = vact_q;
      vcnt_d   = {9'd0, hs_lead};
      vact_d   = {9'd0, line_end};
      p_htot_d = htot_d;
      p_hact_d = hactm_d;
      locked_d = (htot_d == p_htot_q) && (hactm_d == p_hact_q) &&
                 (vcnt_q == vtot_q) && (vact_q == vactm_q) &&
                 (hactm_d == HRez10) && (vact_q == VRez10);
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    line_d    = line_q;
    wcnt_d    = wcnt_q;
    case (state_q)
      IDLE: if (cap_start) begin
        state_d = ARMED;
        err_d   = 1'b0;
        busy_d  = 1'b1;
      end
      ARMED: if (vs_lead) begin
        state_d = CAPTURE;
        addr_d  = '0;
        line_d  = '0;
        wcnt_d  = '0;
      end
      CAPTURE: begin
        if (s_act_q) begin
          if (addr_q <= LastAddr) begin
            wr_en_d   = 1'b1;
            wr_data_d = s_data_q;
            wr_addr_d = addr_q;
            addr_d    = addr_q + 19'd1;
          end else begin
            err_d = 1'b1;
          end
          wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 11'd1;
        end
        if (line_end) begin
          if (wcnt_q != HRez11) err_d = 1'b1;
          line_d = line_q + 10'd1;
          wcnt_d = '0;
        end
        // Completing the last line takes precedence over a coincident vsync edge.
        if (line_end && (line_q == VRez10 - 10'd1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (vs_lead) begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      s_data_q <= '0; s_hs_q <= 1'b0; s_vs_q <= 1'b0; s_act_q <= 1'b0;
      d_hs_q   <= 1'b0; d_vs_q <= 1'b0; d_act_q <= 1'b0;
      hcnt_q   <= '0; hact_q <= '0; vcnt_q <= '0; vact_q <= '0;
      htot_q   <= '0; hactm_q <= '0; vtot_q <= '0; vactm_q <= '0;
      p_htot_q <= '0; p_hact_q <= '0; locked_q <= 1'b0;
      state_q  <= IDLE;
      busy_q   <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; wr_en_q <= 1'b0;
      wr_addr_q <= '0; wr_data_q <= '0; addr_q <= '0; line_q <= '0; wcnt_q <= '0;
    end else begin
      s_data_q <= hdmi_data; s_hs_q <= hdmi_hsync; s_vs_q <= hdmi_vsync;
      s_act_q  <= hdmi_active_video;
      d_hs_q   <= s_hs_q; d_vs_q <= s_vs_q; d_act_q <= s_act_q;
      hcnt_q   <= hcnt_d; hact_q <= hact_d; vcnt_q <= vcnt_d; vact_q <= vact_d;
      htot_q   <= htot_d; hactm_q <= hactm_d; vtot_q <= vtot_d; vactm_q <= vactm_d;
      p_htot_q <= p_htot_d; p_hact_q <= p_hact_d; locked_q <= locked_d;
      state_q  <= state_d;
      busy_q   <= busy_d; done_q <= done_d; err_q <= err_d; wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d; addr_q <= addr_d;
      line_q   <= line_d; wcnt_q <= wcnt_d;
    end
  end

  assign cap_busy     = busy_q;
  assign cap_done     = done_q;
  assign cap_err      = err_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign meas_htotal  = htot_q;
  assign meas_hactive = hactm_q;
  assign meas_vtotal  = vtot_q;
  assign meas_vactive = vactm_q;
  assign locked       = locked_q;
endmodule

// File: tb/tb_hdmi_capture.sv
// Bench for hdmi_capture on a scaled-down 8x6 (12x9 total) stream with a
// frame-level reference model for writes, capture status and timing measurement.
module tb_hdmi_capture;
  localparam int HR = 8, VR = 6, HT = 12, TOTAL = HR * VR;

  logic        clk24 = 1'b0, rst = 1'b1;
  logic [47:0] hdmi_data = '0;
  logic        hdmi_hsync = 1'b1, hdmi_vsync = 1'b1, hdmi_active_video = 1'b0, cap_start = 1'b0;
  logic        cap_busy, cap_done, cap_err, wr_en, locked;
  logic [18:0] wr_addr;
  logic [47:0] wr_data;
  logic [9:0]  meas_htotal, meas_hactive, meas_vtotal, meas_vactive;

  hdmi_capture #(.hRez(HR), .vRez(VR), .hsync_active(1'b0), .vsync_active(1'b0)) dut (
    .clk24(clk24), .rst(rst), .hdmi_data(hdmi_data), .hdmi_hsync(hdmi_hsync),
    .hdmi_vsync(hdmi_vsync), .hdmi_active_video(hdmi_active_video), .cap_start(cap_start),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_err(cap_err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .meas_htotal(meas_htotal),
    .meas_hactive(meas_hactive), .meas_vtotal(meas_vtotal), .meas_vactive(meas_vactive),
    .locked(locked)
  );

  always #5 clk24 = ~clk24;

  int          n_checks = 0, n_errors = 0;
  logic [66:0] exp_q[$];
  int          lens[VR];
  bit          model_cap = 1'b0, cnt_pat = 1'b0, prev_done = 1'b0;
  int          n_wr = 0, done_cnt = 0, ecount = 0, prev_vt = 0, prev_nl = 0;
  int          p_tup[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk24) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (wr_en) begin
        n_wr++;
        if (exp_q.size() == 0) check("wr_unexpected", 64'(wr_en), 64'(0));
        else begin
          logic [66:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e[66:48]));
          check("wr_data", 64'(wr_data), 64'(e[47:0]));
        end
      end
      if (cap_done) begin
        done_cnt++;
        check("done_busy", 64'(cap_busy), 64'(0));
        check("done_width", 64'(prev_done), 64'(0));
      end
      prev_done = cap_done;
    end
  end

  // One frame: nl active lines (lengths from lens[]), vsync low for two lines after them.
  task automatic run_frame(input int vt, input int nl, input int cs_a, input int cs_b);
    int vs_line, widx, pos, cur_vt, cur[4];
    bit act, exp_lock;
    vs_line = nl + 1; widx = 0; pos = 0;
    for (int y = 0; y < vt; y++) begin
      for (int x = 0; x < HT; x++) begin
        @(negedge clk24);
        act = (y < nl) && (x < lens[y]);
        hdmi_active_video = act;
        hdmi_hsync = (x >= HR + 2 && x < HR + 4) ? 1'b0 : 1'b1;
        hdmi_vsync = (y == vs_line || y == vs_line + 1) ? 1'b0 : 1'b1;
        cap_start = (pos == cs_a || pos == cs_b);
        if (act && cnt_pat) hdmi_data = 48'(widx);
        else hdmi_data = {16'($urandom), $urandom};
        if (act) begin
          if (model_cap && widx < TOTAL) exp_q.push_back({19'(widx), hdmi_data});
          widx++;
        end
        if (cs_a >= 0 && pos == cs_a + 1) begin
          check("busy_rise", 64'(cap_busy), 64'(1));
          check("err_clear", 64'(cap_err), 64'(0));
        end
        pos++;
      end
    end
    cap_start = 1'b0;
    if (ecount >= 1) begin
      cur_vt = prev_vt - prev_nl + nl;
      cur = '{HT, lens[nl-1], cur_vt, nl};
      check("meas_htotal", 64'(meas_htotal), 64'(cur[0]));
      check("meas_hactive", 64'(meas_hactive), 64'(cur[1]));
      check("meas_vtotal", 64'(meas_vtotal), 64'(cur[2]));
      check("meas_vactive", 64'(meas_vactive), 64'(cur[3]));
      if (ecount >= 2) begin
        exp_lock = (cur == p_tup) && (cur[1] == HR) && (cur[3] == VR);
        check("locked", 64'(locked), 64'(exp_lock));
      end
      p_tup = cur;
    end
    prev_vt = vt; prev_nl = nl; ecount++;
  endtask

  task automatic clear_counts();
    n_wr = 0; done_cnt = 0; exp_q.delete();
  endtask

  task automatic arm_frame();
    run_frame(9, VR, (VR + 1) * HT - 6, -1);
  endtask

  task automatic capture_frame(input int nl, input int cs_b);
    model_cap = 1'b1; cnt_pat = 1'b1;
    run_frame(9, nl, -1, cs_b);
    model_cap = 1'b0; cnt_pat = 1'b0;
  endtask

  task automatic verify(input string tag, input int nl);
    int tot;
    bit e;
    tot = 0; e = (nl < VR);
    for (int i = 0; i < nl; i++) begin
      tot += lens[i];
      if (lens[i] != HR) e = 1'b1;
    end
    if (tot > TOTAL) e = 1'b1;
    check({tag, "_writes"}, 64'(n_wr), 64'((tot < TOTAL) ? tot : TOTAL));
    check({tag, "_done"}, 64'(done_cnt), 64'(1));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_err"}, 64'(cap_err), 64'(e));
    check({tag, "_busy"}, 64'(cap_busy), 64'(0));
    foreach (lens[i]) lens[i] = HR;
  endtask

  task automatic check_reset_outs();
    check("rst_outs", 64'(|{cap_busy, cap_done, cap_err, wr_en, wr_addr, wr_data, meas_htotal,
                            meas_hactive, meas_vtotal, meas_vactive, locked}), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (lens[i]) lens[i] = HR;
    // Reset held across the first part of a frame, released mid-frame.
    fork
      run_frame(9, VR, -1, -1);
      begin
        repeat (40) @(negedge clk24);
        check_reset_outs();
        @(negedge clk24); #1 rst = 1'b0; ecount = 0;
      end
    join
    repeat (3) run_frame(9, VR, -1, -1);

    // Clean counting-pattern capture.
    clear_counts(); arm_frame(); capture_frame(VR, -1); verify("clean", VR);

    // One short line: error, capture still runs to the end; error stays sticky.
    clear_counts(); arm_frame(); lens[2] = HR - 1; capture_frame(VR, -1); verify("short", VR);
    run_frame(9, VR, -1, -1);
    check("err_sticky", 64'(cap_err), 64'(1));

    // Early vsync after 4 of 6 lines.
    clear_counts(); arm_frame(); capture_frame(4, -1); verify("early", 4);

    // One long line pushes total words past the buffer.
    clear_counts(); arm_frame(); lens[3] = HR + 1; capture_frame(VR, -1); verify("ovf", VR);

    // cap_start on the vsync edge arms only; a repeat during capture is ignored.
    clear_counts();
    run_frame(9, VR, (VR + 1) * HT + 1, -1);
    run_frame(9, VR, -1, -1);
    capture_frame(VR, 2 * HT + 3);
    verify("coinc", VR);

    // Alternating vertical totals never lock.
    run_frame(10, VR, -1, -1);
    run_frame(9, VR, -1, -1);
    run_frame(10, VR, -1, -1);
    run_frame(9, VR, -1, -1);

    // Reset in the middle of a capture aborts it without cap_done.
    clear_counts(); arm_frame();
    model_cap = 1'b1; cnt_pat = 1'b1;
    fork
      run_frame(9, VR, -1, -1);
      begin
        repeat (30) @(negedge clk24);
        #1 rst = 1'b1; model_cap = 1'b0; exp_q.delete();
        @(negedge clk24);
        check_reset_outs();
        n_wr = 0; done_cnt = 0;
        @(negedge clk24); #1 rst = 1'b0; ecount = 0;
      end
    join
    cnt_pat = 1'b0;
    run_frame(9, VR, -1, -1);
    check("abort_done", 64'(done_cnt), 64'(0));
    check("abort_writes", 64'(n_wr), 64'(0));
    check("abort_busy", 64'(cap_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
